// File: rtl/ml_conv_window_gen.sv
// Streaming 3x3 sliding-window generator: turns a raster pixel stream into
// "valid" convolution windows, (H-2)x(W-2) of them per frame.
module ml_conv_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 64,
  parameter int unsigned DIM_W  = 7
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_width,
  input  logic [DIM_W-1:0]      cfg_height,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [9*DATA_W-1:0]   m_window,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]   w_q, h_q, col_q, row_q;
  logic [AW-1:0]      col_idx;
  logic               accept, cfg_ok, emit, is_last, out_hs, frame_go;
  logic [DATA_W-1:0]  lb0 [MAX_W];
  logic [DATA_W-1:0]  lb1 [MAX_W];
  logic [9*DATA_W-1:0] win_nxt;

  assign col_idx  = col_q[AW-1:0];
  assign s_ready  = (state == STREAM) && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign out_hs   = m_valid && m_ready;
  assign cfg_ok   = (cfg_width >= DIM_W'(3)) && (cfg_width <= DIM_W'(MAX_W)) &&
                    (cfg_height >= DIM_W'(3));
  assign frame_go = (state == IDLE) && start && cfg_ok;
  // Only positions with two full rows and two full columns behind them emit.
  assign emit     = accept && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
  assign is_last  = accept && (row_q == h_q - DIM_W'(1)) && (col_q == w_q - DIM_W'(1));

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_go) state_nxt = STREAM;
      STREAM:  if (is_last) state_nxt = FLUSH;
      FLUSH:   if (out_hs && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame geometry and raster position
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_q   <= '0;
      h_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (frame_go) begin
      w_q   <= cfg_width;
      h_q   <= cfg_height;
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == w_q - DIM_W'(1)) begin
        col_q <= '0;
        row_q <= row_q + DIM_W'(1);
      end else begin
        col_q <= col_q + DIM_W'(1);
      end
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the one before it.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      lb0[col_idx] <= s_data;
      lb1[col_idx] <= lb0[col_idx];
    end
  end

  // Shift window left; new right column is {oldest, previous, current} row.
  always_comb begin
    win_nxt = m_window;
    for (int r = 0; r < 3; r++) begin
      win_nxt[DATA_W*(3*r)   +: DATA_W] = m_window[DATA_W*(3*r+1) +: DATA_W];
      win_nxt[DATA_W*(3*r+1) +: DATA_W] = m_window[DATA_W*(3*r+2) +: DATA_W];
    end
    win_nxt[DATA_W*2 +: DATA_W] = lb1[col_idx];
    win_nxt[DATA_W*5 +: DATA_W] = lb0[col_idx];
    win_nxt[DATA_W*8 +: DATA_W] = s_data;
  end

  // Output stage; the window only moves on acceptance, which a stall blocks.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_window <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (accept) m_window <= win_nxt;
      if (emit) begin
        m_valid <= 1'b1;
        m_last  <= is_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      busy    <= (state_nxt != IDLE);
      done    <= (state == FLUSH) && out_hs && m_last;
      cfg_err <= (state == IDLE) && start && !cfg_ok;
    end
  end

endmodule

// File: tb/tb_ml_conv_window_gen.sv
// Directed self-checking bench for ml_conv_window_gen.
module tb_ml_conv_window_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_W  = 64;
  localparam int unsigned DIM_W  = 7;
  localparam int unsigned WIN_W  = 9 * DATA_W;
  localparam int BUDGET = 2000;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_width = '0;
  logic [DIM_W-1:0]  cfg_height = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [WIN_W-1:0]  m_window;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  ml_conv_window_gen #(.DATA_W(DATA_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window),
    .m_last(m_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int base, input int i);
    return DATA_W'(base + i);
  endfunction

  function automatic logic [WIN_W-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [WIN_W-1:0] v;
    v = {DATA_W'(a8), DATA_W'(a7), DATA_W'(a6), DATA_W'(a5), DATA_W'(a4),
         DATA_W'(a3), DATA_W'(a2), DATA_W'(a1), DATA_W'(a0)};
    return v;
  endfunction

  // Window k covers image rows k/(w-2)..+2 and columns k%(w-2)..+2.
  function automatic logic [WIN_W-1:0] exp_win(input int w, input int base, input int k);
    logic [WIN_W-1:0] v;
    int nr, nc;
    nr = k / (w - 2);
    nc = k % (w - 2);
    v = '0;
    for (int er = 0; er < 3; er++)
      for (int ec = 0; ec < 3; ec++)
        v[DATA_W*(3*er+ec) +: DATA_W] = pix(base, (nr + er) * w + nc + ec);
    return v;
  endfunction

  // Caller must be between a negedge and the following posedge.
  task automatic run_frame(input int w, input int h, input int base, input int rdy_mode,
                           input int gap_mode, output logic [WIN_W-1:0] first_win,
                           output logic [WIN_W-1:0] last_win);
    int idx, nout, hs_first, hs_last;
    bit got_done, prev_stall;
    logic [WIN_W-1:0] prev_win;
    idx = 0; nout = 0; hs_first = -1; hs_last = -10;
    got_done = 0; prev_stall = 0; prev_win = '0;
    first_win = '0; last_win = '0;
    start = 1'b1; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); s_valid = 1'b0;
    @(negedge ACLK);
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("done_is_pulse", done, 0);
    for (int cyc = 0; cyc < BUDGET && !got_done; cyc++) begin
      s_valid = (idx < w * h) && !(gap_mode != 0 && (cyc % 3) == 2);
      s_data  = pix(base, idx);
      m_ready = (rdy_mode != 0) ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (prev_stall) begin
        chk("win_stable", m_window, prev_win);
        chk("valid_held", m_valid, 1);
      end
      if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
      prev_stall = m_valid && !m_ready;
      prev_win   = m_window;
      if (done) begin
        chk("done_timing", cyc, hs_last + 1);
        got_done = 1;
      end
      if (m_valid && m_ready) begin
        chk("window", m_window, exp_win(w, base, nout));
        chk("m_last", m_last, (nout == (h - 2) * (w - 2) - 1));
        if (nout == 0) begin first_win = m_window; hs_first = cyc; end
        last_win = m_window;
        hs_last = cyc;
        nout++;
      end
      if (s_valid && s_ready) idx++;
      if (!got_done) @(negedge ACLK);
    end
    s_valid = 1'b0;
    if (!got_done) chk("frame_timeout", 0, 1);
    chk("window_count", nout, (h - 2) * (w - 2));
    if (h == 3 && rdy_mode == 0 && gap_mode == 0)
      chk("no_bubbles", hs_last - hs_first, nout - 1);
  endtask

  initial begin
    logic [WIN_W-1:0] fw, lw;
    int acc;

    // Reset state
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_window", m_window, '0);
    chk("rst_busy", busy, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 4x4, always ready
    run_frame(4, 4, 1, 0, 0, fw, lw);
    chk("4x4_first", fw, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("4x4_last", lw, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    @(negedge ACLK);

    // 4x4, m_ready toggling
    run_frame(4, 4, 1, 1, 0, fw, lw);
    chk("4x4_tog_first", fw, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("4x4_tog_last", lw, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    @(negedge ACLK);

    // Illegal config, then smallest legal frame
    start = 1'b1; cfg_width = DIM_W'(2); cfg_height = DIM_W'(5);
    @(negedge ACLK);
    start = 1'b0;
    #1;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_s_ready", s_ready, 0);
    @(negedge ACLK);
    #1;
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_err_idle", busy, 0);
    run_frame(3, 3, 1, 0, 0, fw, lw);
    chk("3x3_window", fw, pack9(1, 2, 3, 4, 5, 6, 7, 8, 9));
    @(negedge ACLK);

    // Maximum width ramp
    run_frame(64, 3, 0, 0, 0, fw, lw);
    chk("ramp_first", fw, pack9(0, 1, 2, 64, 65, 66, 128, 129, 130));
    chk("ramp_last", lw, pack9(61, 62, 63, 125, 126, 127, 189, 190, 191));
    @(negedge ACLK);

    // Reset mid-frame after 7 pixels
    start = 1'b1; cfg_width = DIM_W'(4); cfg_height = DIM_W'(4);
    @(negedge ACLK);
    start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 7; cyc++) begin
      s_valid = 1'b1; s_data = pix(1, acc); m_ready = 1'b1;
      #1;
      if (s_ready) acc++;
      @(negedge ACLK);
    end
    s_valid = 1'b0;
    chk("pre_reset_pixels", acc, 7);
    ARESET = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_window", m_window, '0);
    chk("arst_m_last", m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cfg_err", cfg_err, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    run_frame(4, 4, 101, 0, 0, fw, lw);
    chk("post_reset_first", fw, pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));

    // Back-to-back frames: start lands while done is still high
    run_frame(5, 4, 200, 1, 1, fw, lw);
    chk("b2b_first", fw, pack9(200, 201, 202, 205, 206, 207, 210, 211, 212));
    chk("b2b_last", lw, pack9(207, 208, 209, 212, 213, 214, 217, 218, 219));
    @(negedge ACLK);
    #1;
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
